// File: rtl/hy_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the buffered-instruction record and the NOP/reset defaults.
package hy_fetch_pkg;

    localparam logic [31:0] HY_NOP      = 32'h0000_0013;
    localparam logic [31:0] HY_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fifo_entry_t;

endpackage

// File: rtl/hy_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push.
// Latency: an entry pushed at an edge is visible on rd_dat after that edge.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module hy_fetch_fifo
    import hy_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fifo_entry_t              wr_dat,
    output fifo_entry_t              rd_dat,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (occupancy == '0);
    assign full   = (occupancy == (AW+1)'(DEPTH));

endmodule

// File: rtl/hy_riscv_fetch_unit.sv
// Instruction fetch: PC, memory requests, instruction buffer and redirect flush; perf counters under HY_FETCH_PERF_CNT_EN.
// Latency: 2 cycles minimum from request handshake to push_ops with a 1-cycle memory.
// Backpressure: issue throttled by buffer space and MAX_OUTSTANDING; core_ready stalls the buffer head.
module hy_riscv_fetch_unit
    import hy_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = HY_RESET_PC,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    input  logic        core_ready,
    output logic [31:0] opcode,
    output logic        push_ops,
    output logic [31:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`ifdef HY_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc, rsp_pc, redirect_tgt;
    logic [CW-1:0] outstanding, outstanding_nxt, discard, occupancy;
    logic          fifo_empty, fifo_full;
    logic          issue_ok, req_hs, rsp_accept, rsp_push, rsp_fault;
    fifo_entry_t   fifo_wr_dat, fifo_rd_dat;
    logic          unused_bits;

    assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
    assign issue_ok        = (({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(FIFO_DEPTH))
                           && (outstanding < CW'(MAX_OUTSTANDING));
    assign req_hs          = mem_req_valid && mem_req_ready;
    // Responses are only kept in RUN; HALT counts them but ignores them.
    assign rsp_accept      = mem_rsp_valid && !redirect_valid && (state == RUN) && (discard == '0);
    assign rsp_push        = rsp_accept && !mem_rsp_err;
    assign rsp_fault       = rsp_accept && mem_rsp_err;
    assign outstanding_nxt = outstanding + CW'(req_hs) - CW'(mem_rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = (outstanding_nxt != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN:     if (rsp_fault) state_nxt = HALT;
                FLUSH:   if (mem_rsp_valid && (discard == CW'(1))) state_nxt = RUN;
                HALT:    state_nxt = HALT;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        mem_req_valid = !reset && (state == RUN) && issue_ok && !redirect_valid;
        mem_req_addr  = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc      <= redirect_tgt;
                rsp_pc  <= redirect_tgt;
                discard <= outstanding_nxt;
            end else begin
                if (req_hs)   pc     <= pc + 32'd4;
                if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
                if ((state == FLUSH) && mem_rsp_valid) discard <= discard - CW'(1);
                if (rsp_fault) begin
                    fetch_fault <= 1'b1;
                    fault_pc    <= rsp_pc;
                end
            end
        end
    end

    assign fifo_wr_dat = '{pc: rsp_pc, instr: mem_rsp_data};

    hy_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .pop       (push_ops),
        .flush     (redirect_valid),
        .wr_dat    (fifo_wr_dat),
        .rd_dat    (fifo_rd_dat),
        .occupancy (occupancy),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // With an empty buffer, fetch_pc shows the PC the next response will carry.
    assign push_ops = !fifo_empty && core_ready && !redirect_valid;
    assign opcode   = fifo_empty ? HY_NOP : fifo_rd_dat.instr;
    assign fetch_pc = fifo_empty ? rsp_pc : fifo_rd_dat.pc;

    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

`ifdef HY_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push_ops) perf_fetched <= perf_fetched + 32'd1;
            if (core_ready && fifo_empty && !redirect_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hy_riscv_fetch_unit.sv
// Directed bench for hy_riscv_fetch_unit with a latency-configurable memory model and
// an epoch-tagged scoreboard of expected {pc, instr} pushes.
module tb_hy_riscv_fetch_unit;
    import hy_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_data;
    logic        core_ready;
    logic [31:0] opcode, fetch_pc, redirect_pc, fault_pc;
    logic        push_ops, redirect_valid, fetch_fault;
`ifdef HY_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;

    hy_riscv_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .core_ready     (core_ready),
        .opcode         (opcode),
        .push_ops       (push_ops),
        .fetch_pc       (fetch_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`ifdef HY_FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } pend_t;

    pend_t       pend[$];
    fifo_entry_t exp_q[$];
    pend_t       rsp_cur;
    int          cyc, lat, epoch;
    bit          halted, err_en;
    logic [31:0] err_addr;
    int          n_checks, n_fail, n_hs, n_push, pf_push, pf_stall;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0050_0093;
            32'h8000_0004: return 32'h00a0_0113;
            default:       return {a[15:0], 16'h0093};
        endcase
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: score outputs and capture traffic at negedge, then drive the memory response.
    task automatic tick();
        fifo_entry_t e;
        @(negedge clk);
        if (!reset) begin
            if (redirect_valid) chk1("push_on_redirect", push_ops, 1'b0);
            if (push_ops) begin
                n_push++;
                pf_push++;
                if (exp_q.size() == 0) begin
                    chk1("unexpected_push", push_ops, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk32("sb_fetch_pc", fetch_pc, e.pc);
                    chk32("sb_opcode", opcode, e.instr);
                end
            end
            if (core_ready && !push_ops && !redirect_valid) pf_stall++;
            if (mem_rsp_valid && (rsp_cur.ep == epoch) && !halted) begin
                if (mem_rsp_err) halted = 1'b1;
                else exp_q.push_back('{pc: rsp_cur.addr, instr: instr_at(rsp_cur.addr)});
            end
            if (mem_req_valid && mem_req_ready) begin
                n_hs++;
                pend.push_back('{addr: mem_req_addr, due: cyc + lat, ep: epoch});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!reset && (pend.size() > 0) && (pend[0].due <= cyc)) begin
            rsp_cur       = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = instr_at(rsp_cur.addr);
            mem_rsp_err   = err_en && (rsp_cur.addr == err_addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            mem_rsp_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend.delete();
        exp_q.delete();
        halted = 1'b0;
        mem_rsp_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        pf_push = 0;
        pf_stall = 0;
        n_hs = 0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        epoch++;
        halted = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_req(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chk1(tag, got, 1'b1);
    endtask

    task automatic wait_push(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (push_ops) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chk1(tag, got, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_req_valid"}, mem_req_valid, 1'b0);
        chk1({tag, "_push_ops"}, push_ops, 1'b0);
        chk32({tag, "_opcode"}, opcode, 32'h0000_0013);
        chk32({tag, "_fetch_pc"}, fetch_pc, 32'h8000_0000);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
        chk32({tag, "_fault_pc"}, fault_pc, 32'h0);
    endtask

    int hs_mark;

    initial begin
        reset = 1'b1; core_ready = 1'b0; mem_req_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        cyc = 0; lat = 1; epoch = 0; halted = 1'b0; err_en = 1'b0; err_addr = '0;
        n_checks = 0; n_fail = 0; n_hs = 0; n_push = 0; pf_push = 0; pf_stall = 0;
        #2;
        chk_reset_vals("rst");

        // Basic streaming: address sequence and 2-cycle request-to-push latency.
        core_ready = 1'b1; mem_req_ready = 1'b1;
        do_reset();
        #1;
        chk1("t1_req_valid", mem_req_valid, 1'b1);
        chk32("t1_addr0", mem_req_addr, 32'h8000_0000);
        tick(); #1;
        chk32("t1_addr1", mem_req_addr, 32'h8000_0004);
        chk1("t1_no_bypass", push_ops, 1'b0);
        tick(); #1;
        chk1("t1_first_push", push_ops, 1'b1);
        chk32("t1_pc0", fetch_pc, 32'h8000_0000);
        chk32("t1_op0", opcode, 32'h0050_0093);
        tick(); #1;
        chk32("t1_pc1", fetch_pc, 32'h8000_0004);
        chk32("t1_op1", opcode, 32'h00a0_0113);

        // Core stalled: buffer fills to exactly FIFO_DEPTH, then drains back-to-back.
        core_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        #1;
        chk32("t2_hs_count", n_hs, 32'd4);
        chk1("t2_req_stopped", mem_req_valid, 1'b0);
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("t2_drain", push_ops, 1'b1);
            tick();
        end
        repeat (3) tick();
        #1;
        chk1("t2_resume", n_hs > 4, 1'b1);

        // Slow memory with two in flight, then redirect: stale responses must be dropped.
        lat = 3;
        repeat (6) tick();
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (pend.size() == 2 && !mem_rsp_valid) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            chk1("t3_two_outstanding", found, 1'b1);
        end
        redirect(32'h8000_0103);
        #1;
        chk1("t3_redir_push", push_ops, 1'b0);
        chk1("t3_redir_req", mem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk1("t3_flush_noreq", mem_req_valid, 1'b0);
        wait_req("t3_req_timeout");
        chk32("t3_new_addr", mem_req_addr, 32'h8000_0100);
        wait_push("t3_push_timeout");
        chk32("t3_first_pc", fetch_pc, 32'h8000_0100);

        // Bus error at 80000008: sticky fault, halt issue, drain earlier entries, redirect resumes.
        lat = 1; core_ready = 1'b0; err_en = 1'b1; err_addr = 32'h8000_0008;
        do_reset();
        repeat (8) tick();
        #1;
        chk1("t4_fault", fetch_fault, 1'b1);
        chk32("t4_fault_pc", fault_pc, 32'h8000_0008);
        chk1("t4_halt_noreq", mem_req_valid, 1'b0);
        hs_mark = n_hs;
        n_push = 0;
        core_ready = 1'b1;
        repeat (6) tick();
        #1;
        chk32("t4_drained", n_push, 32'd2);
        chk32("t4_no_issue_in_halt", n_hs, hs_mark);
        err_en = 1'b0;
        redirect(32'h8000_0200);
        tick();
        redirect_valid = 1'b0;
        #1;
        wait_req("t4_req_timeout");
        chk32("t4_resume_addr", mem_req_addr, 32'h8000_0200);
        chk1("t4_fault_sticky", fetch_fault, 1'b1);
        wait_push("t4_push_timeout");
        chk32("t4_resume_pc", fetch_pc, 32'h8000_0200);

        // Redirect with a non-empty buffer, then async reset while flushing.
        core_ready = 1'b0; lat = 3;
        repeat (8) tick();
        core_ready = 1'b1;
        redirect(32'h8000_0300);
        #1;
        chk1("t5_push_blocked", push_ops, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk1("t5_empty_push", push_ops, 1'b0);
        chk32("t5_empty_nop", opcode, 32'h0000_0013);
        tick();
        tick();
        redirect(32'h8000_0400);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk1("t5_flush_noreq", mem_req_valid, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("t5_async");

        // Back-to-back redirects: the last target wins.
        lat = 1;
        do_reset();
        redirect(32'h8000_0500);
        tick();
        redirect(32'h8000_0600);
        tick();
        redirect_valid = 1'b0;
        #1;
        wait_req("t6_req_timeout");
        chk32("t6_last_wins", mem_req_addr, 32'h8000_0600);
        wait_push("t6_push_timeout");
        chk32("t6_first_pc", fetch_pc, 32'h8000_0600);
        repeat (6) tick();
        #1;

`ifdef HY_FETCH_PERF_CNT_EN
        chk32("perf_fetched", perf_fetched, pf_push);
        chk32("perf_stall", perf_stall, pf_stall);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
